heartbeat_frame_sched: RTL and testbench

- Shares one Manchester-encoded serial heartbeat pin between NUM_REQ on-die requesters.
- Each requester offers an 8-bit payload over a valid/ready handshake.
- A round-robin arbiter grants one requester per frame. A framer then serialises preamble, flag, source ID and payload, Manchester-encoded at two clocks per bit.
- When the line has been idle for IDLE_CYCLES, the block inserts an autonomous heartbeat frame carrying an internal 8-bit sequence counter. This keeps the pad alive when no requester is active.

---
 rtl/heartbeat_frame_sched.sv | 171 +++++++++++++++++
 tb/tb_heartbeat_frame_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_frame_sched.sv
// Round-robin scheduler sharing one Manchester heartbeat pin between NUM_REQ requesters.
// Inserts an autonomous heartbeat frame carrying a sequence counter after IDLE_CYCLES quiet clocks.
module heartbeat_frame_sched #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_BITS      = 2,
  parameter int IDLE_CYCLES   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(IDLE_CYCLES);
  localparam int SH_W  = ID_W + 8;

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_FLAG, S_ID, S_DATA, S_GAP} state_t;

  localparam state_t FIRST_STATE = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_FLAG;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              hb_flag_q, hb_flag_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]        hb_seq_q, hb_seq_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    arb_idx;
  logic               found;
  logic [7:0]         grant_data;
  logic [7:0]         field_len;
  logic               field_end;
  logic               tx_bit;

  // Rotating-priority search starting just after the previous grantee.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    arb_idx  = '0;
    found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      arb_idx = ID_W'((int'(last_grant_q) + off) % NUM_REQ);
      if (!found && req_valid[arb_idx]) begin
        found          = 1'b1;
        grant[arb_idx] = 1'b1;
        grant_id       = arb_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    field_len = 8'd1;
    case (state_q)
      S_PREAMBLE: field_len = 8'(PREAMBLE_BITS);
      S_ID:       field_len = 8'(ID_W);
      S_DATA:     field_len = 8'd8;
      S_GAP:      field_len = 8'(GAP_BITS);
      default:    field_len = 8'd1;
    endcase
  end

  // ID and payload leave MSB-first from one shift register loaded at grant.
  always_comb begin
    tx_bit = 1'b0;
    case (state_q)
      S_PREAMBLE:   tx_bit = ~bit_cnt_q[0];
      S_FLAG:       tx_bit = hb_flag_q;
      S_ID, S_DATA: tx_bit = shift_q[SH_W-1];
      default:      tx_bit = 1'b0;
    endcase
  end

  assign field_end  = phase_q && (bit_cnt_q == field_len - 8'd1);
  assign busy       = (state_q != S_IDLE);
  assign req_ready  = (state_q == S_IDLE && !rst) ? grant : '0;
  assign serial_out = (state_q inside {S_PREAMBLE, S_FLAG, S_ID, S_DATA}) ? (tx_bit ^ phase_q) : 1'b0;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    hb_flag_d    = hb_flag_q;
    idle_cnt_d   = idle_cnt_q;
    hb_seq_d     = hb_seq_q;
    frame_done   = 1'b0;

    if (state_q == S_IDLE) begin
      phase_d   = 1'b0;
      bit_cnt_d = '0;
      if (found) begin
        state_d      = FIRST_STATE;
        last_grant_d = grant_id;
        shift_d      = {grant_id, grant_data};
        hb_flag_d    = 1'b0;
        idle_cnt_d   = '0;
      end else if (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
        state_d    = FIRST_STATE;
        shift_d    = {{ID_W{1'b0}}, hb_seq_q};
        hb_flag_d  = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
      phase_d    = ~phase_q;
      if (phase_q) begin
        if (state_q inside {S_ID, S_DATA}) shift_d = shift_q << 1;
        if (field_end) begin
          bit_cnt_d = '0;
          case (state_q)
            S_PREAMBLE: state_d = S_FLAG;
            S_FLAG:     state_d = S_ID;
            S_ID:       state_d = S_DATA;
            S_DATA:     state_d = S_GAP;
            S_GAP: begin
              state_d    = S_IDLE;
              frame_done = 1'b1;
              if (hb_flag_q) hb_seq_d = hb_seq_q + 8'd1;
            end
            default:    state_d = S_IDLE;
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      shift_q      <= '0;
      hb_flag_q    <= 1'b0;
      idle_cnt_q   <= '0;
      hb_seq_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      hb_flag_q    <= hb_flag_d;
      idle_cnt_q   <= idle_cnt_d;
      hb_seq_q     <= hb_seq_d;
    end
  end

endmodule

// File: tb/tb_heartbeat_frame_sched.sv
// Self-checking bench for heartbeat_frame_sched: decodes every frame off the Manchester pin
// and compares it with a frame-level model of arbitration, idle timing and the heartbeat counter.
module tb_heartbeat_frame_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int PRE     = 4;
  localparam int GAP     = 2;
  localparam int IDLE    = 16;
  localparam int F       = PRE + 1 + ID_W + 8;
  localparam int BUSY    = 2*F + 2*GAP;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 serial_out;
  logic                 busy;
  logic                 frame_done;

  int checks;
  int errors;
  int lastGrant;
  int hbSeq;

  heartbeat_frame_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .PREAMBLE_BITS(PRE),
    .GAP_BITS(GAP), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Round-robin rule: first valid requester after the previous grantee, wrapping around.
  function automatic int pickGrant(input logic [3:0] mask, input int last);
    int pick;
    int idx;
    pick = -1;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (last + off) % NUM_REQ;
      if (pick < 0 && mask[idx[1:0]]) pick = idx;
    end
    return pick;
  endfunction

  // Entered on the negedge of the first busy cycle; leaves on the negedge of the first idle cycle.
  task automatic collectFrame(input logic expFlag, input logic [1:0] expId, input logic [7:0] expPay);
    logic [BUSY-1:0] halves;
    logic [F-1:0]    bits;
    int              badHalf;
    halves = '0;
    bits   = '0;
    for (int c = 0; c < BUSY; c++) begin
      if (c > 0) @(negedge clk);
      halves[c] = serial_out;
      checkOutput("frame_ctl", {26'd0, busy, frame_done, req_ready},
                  {26'd0, 1'b1, (c == BUSY-1), 4'b0000});
    end
    badHalf = 0;
    for (int b = 0; b < F; b++) begin
      bits[F-1-b] = halves[2*b];
      if (halves[2*b+1] !== ~halves[2*b]) badHalf++;
    end
    checkOutput("manchester", badHalf, 0);
    checkOutput("gap_low", {28'd0, halves[BUSY-1:2*F]}, 32'd0);
    checkOutput("preamble", {28'd0, bits[F-1:F-PRE]}, 32'hA);
    checkOutput("flag", {31'd0, bits[F-PRE-1]}, {31'd0, expFlag});
    checkOutput("src_id", {30'd0, bits[9:8]}, {30'd0, expId});
    checkOutput("payload", {24'd0, bits[7:0]}, {24'd0, expPay});
    @(negedge clk);
    checkOutput("post_frame", {29'd0, busy, serial_out, frame_done}, 32'd0);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_out", {25'd0, busy, serial_out, frame_done, req_ready}, 32'd0);
    rst       = 1'b0;
    lastGrant = NUM_REQ - 1;
    hbSeq     = 0;
  endtask

  // Presents a request in an idle cycle and checks the whole resulting data frame.
  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] data, input bit holdValid);
    int          g;
    logic [31:0] sh;
    req_valid = mask;
    req_data  = data;
    #1;
    g  = pickGrant(mask, lastGrant);
    sh = data >> (8*g);
    checkOutput("req_ready", {28'd0, req_ready}, 32'd1 << g);
    @(negedge clk);
    checkOutput("frame_start", {30'd0, busy, serial_out}, 32'd3);
    if (!holdValid) begin
      req_valid = '0;
      req_data  = $urandom;
    end
    lastGrant = g;
    collectFrame(1'b0, 2'(g), sh[7:0]);
  endtask

  task automatic expectHeartbeat();
    int waited;
    waited = 0;
    while (busy !== 1'b1 && waited < 3*IDLE) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("hb_delay", waited, IDLE);
    collectFrame(1'b1, 2'd0, 8'(hbSeq));
    hbSeq = (hbSeq + 1) % 256;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_wait", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int          d;
    int          r;
    logic [3:0]  mask;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    lastGrant = NUM_REQ - 1;
    hbSeq     = 0;

    $display("[TB] reset and single request");
    doReset();
    applyStimulus(4'b0001, 32'h000000A5, 1'b0);

    $display("[TB] round robin with all valids held");
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b1111, 32'h44332211, 1'b1);

    $display("[TB] idle heartbeats");
    req_valid = '0;
    expectHeartbeat();
    expectHeartbeat();

    $display("[TB] request colliding with idle timer expiry");
    idleCycles(IDLE - 1);
    applyStimulus(4'b0100, 32'h00C30000, 1'b0);
    expectHeartbeat();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        expectHeartbeat();
      end else begin
        d    = $urandom_range(0, IDLE - 2);
        mask = 4'($urandom_range(1, 15));
        idleCycles(d);
        applyStimulus(mask, $urandom, 1'b0);
      end
    end

    $display("[TB] reset during payload");
    req_valid = 4'b0010;
    req_data  = $urandom;
    #1;
    checkOutput("req_ready_mid", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_out", {29'd0, serial_out, busy, frame_done}, 32'd0);
    rst       = 1'b0;
    lastGrant = NUM_REQ - 1;
    hbSeq     = 0;
    applyStimulus(4'b1111, $urandom, 1'b0);
    applyStimulus(4'b0100, $urandom, 1'b0);

    $display("[TB] heartbeat sequence wrap");
    doReset();
    for (int k = 0; k < 257; k++) expectHeartbeat();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
